// File: rtl/div_seq_rv_if.sv
// Request/result bus of the sequential divider: request channel (in_*) and result channel (out_*).
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface div_seq_rv_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_div0;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_div0
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_div0
    );
endinterface

// File: rtl/div_seq_rv.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU) with tag passthrough, flush and
// single-cycle handling of divide-by-zero and signed overflow.
module div_seq_rv #(
    parameter int WIDTH        = 32,
    parameter int BITS_PER_CYC = 1,
    parameter int TAG_W        = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    div_seq_rv_if.slave bus,
    output logic [1:0]  dbg_state
);
    localparam int N  = WIDTH / BITS_PER_CYC;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]    N_CNT   = CW'(N);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;

    logic             accept;
    logic             is_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             b_zero, ovf;
    logic [WIDTH:0]   trial, diff;
    logic [WIDTH-1:0] step_q, step_r;

    assign bus.in_ready = (state_q == IDLE) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    // Ops with in_op[0]=0 are signed; magnitudes feed the unsigned datapath.
    assign is_signed = ~bus.in_op[0];
    assign a_neg     = is_signed & bus.in_a[WIDTH-1];
    assign b_neg     = is_signed & bus.in_b[WIDTH-1];
    assign a_mag     = a_neg ? (~bus.in_a + 1'b1) : bus.in_a;
    assign b_mag     = b_neg ? (~bus.in_b + 1'b1) : bus.in_b;
    assign b_zero    = (bus.in_b == '0);
    assign ovf       = is_signed && (bus.in_a == MOST_NEG) && (bus.in_b == '1);

    // quo_q starts as the dividend and is shifted out MSB-first while quotient bits shift in.
    always_comb begin
        step_q = quo_q;
        step_r = rem_q;
        trial  = '0;
        diff   = '0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            trial  = {step_r, step_q[WIDTH-1]};
            diff   = trial - {1'b0, dvs_q};
            step_q = {step_q[WIDTH-2:0], ~diff[WIDTH]};
            step_r = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        tag_d     = tag_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = bus.in_op;
                    tag_d     = bus.in_tag;
                    dvs_d     = b_mag;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = b_zero;
                    if (b_zero) begin
                        quo_d   = '1;
                        rem_d   = bus.in_a;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else if (ovf) begin
                        quo_d   = bus.in_a;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        quo_d   = a_mag;
                        rem_d   = '0;
                        cnt_d   = N_CNT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    quo_d = step_q;
                    rem_d = step_r;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Final BUSY cycle applies the sign fix-up to the magnitudes.
                    quo_d   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
                    rem_d   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            tag_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    // Outputs depend only on registers, and are forced to zero outside DONE.
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = (state_q == DONE) ? (op_q[1] ? rem_q : quo_q) : '0;
    assign bus.out_tag    = (state_q == DONE) ? tag_q : '0;
    assign bus.out_div0   = (state_q == DONE) ? div0_q : 1'b0;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_div_seq_rv.sv
// Bench for div_seq_rv: one instance with 1 bit/cycle for directed tests, one with
// 2 bits/cycle for a randomised sweep against a behavioural model.
module tb_div_seq_rv;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] dbg1, dbg2;
    int         total = 0;
    int         bad   = 0;

    logic [31:0] exp_res_q[$];
    logic [5:0]  exp_tag_q[$];
    logic        exp_d0_q[$];
    int          exp_lat_q[$];

    div_seq_rv_if #(.WIDTH(32), .TAG_W(6)) if1 ();
    div_seq_rv_if #(.WIDTH(32), .TAG_W(6)) if2 ();

    div_seq_rv #(.WIDTH(32), .BITS_PER_CYC(1), .TAG_W(6)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if1.slave), .dbg_state(dbg1)
    );
    div_seq_rv #(.WIDTH(32), .BITS_PER_CYC(2), .TAG_W(6)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .bus(if2.slave), .dbg_state(dbg2)
    );

    always #5 clk = ~clk;

    // Behavioural reference; lat counts rising edges after the accept edge until out_valid.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, output logic [31:0] res, output logic d0, output int lat);
        logic [31:0] q, r;
        logic signed [31:0] sa, sb;
        sa  = a;
        sb  = b;
        d0  = 1'b0;
        lat = n + 1;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; d0 = 1'b1; lat = 0;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; lat = 0;
        end else if (!op[0]) begin
            q = $unsigned(sa / sb); r = $unsigned(sa % sb);
        end else begin
            q = a / b; r = a % b;
        end
        res = op[1] ? r : q;
    endtask

    function automatic logic get_ov(input bit sel);
        return sel ? if2.out_valid : if1.out_valid;
    endfunction

    function automatic logic get_rdy(input bit sel);
        return sel ? if2.in_ready : if1.in_ready;
    endfunction

    task automatic drive(input bit sel, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag);
        if (sel) begin
            if2.in_op = op; if2.in_a = a; if2.in_b = b; if2.in_tag = tag; if2.in_valid = 1'b1;
        end else begin
            if1.in_op = op; if1.in_a = a; if1.in_b = b; if1.in_tag = tag; if1.in_valid = 1'b1;
        end
    endtask

    task automatic clear_valid(input bit sel);
        if (sel) if2.in_valid = 1'b0;
        else     if1.in_valid = 1'b0;
    endtask

    task automatic push_exp(input bit sel, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [5:0] tag);
        logic [31:0] res;
        logic        d0;
        int          lat;
        model(op, a, b, sel ? 16 : 32, res, d0, lat);
        exp_res_q.push_back(res);
        exp_tag_q.push_back(tag);
        exp_d0_q.push_back(d0);
        exp_lat_q.push_back(lat);
    endtask

    // Called at the negedge right after the accept edge; bounded wait for out_valid.
    task automatic wait_result(input bit sel, output int lat);
        lat = 0;
        while (get_ov(sel) !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input bit sel, input string name, input int lat);
        logic [31:0] er, ar;
        logic [5:0]  et, at;
        logic        ed, ad;
        int          el;
        er = exp_res_q.pop_front();
        et = exp_tag_q.pop_front();
        ed = exp_d0_q.pop_front();
        el = exp_lat_q.pop_front();
        ar = sel ? if2.out_result : if1.out_result;
        at = sel ? if2.out_tag    : if1.out_tag;
        ad = sel ? if2.out_div0   : if1.out_div0;
        total += 4;
        if (ar !== er) begin bad++; $display("FAIL %s result got=%h exp=%h", name, ar, er); end
        if (at !== et) begin bad++; $display("FAIL %s tag got=%0d exp=%0d", name, at, et); end
        if (ad !== ed) begin bad++; $display("FAIL %s div0 got=%b exp=%b", name, ad, ed); end
        if (lat != el) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, el); end
    endtask

    task automatic run_op(input bit sel, input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        int lat;
        push_exp(sel, op, a, b, tag);
        @(negedge clk);
        drive(sel, op, a, b, tag);
        @(posedge clk);
        @(negedge clk);
        clear_valid(sel);
        wait_result(sel, lat);
        check_result(sel, name, lat);
        @(negedge clk);
        total++;
        if (get_ov(sel) !== 1'b0 || get_rdy(sel) !== 1'b1) begin
            bad++;
            $display("FAIL %s release got valid=%b ready=%b exp valid=0 ready=1",
                     name, get_ov(sel), get_rdy(sel));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total += 6;
        if (if1.out_valid !== 1'b0)   begin bad++; $display("FAIL reset out_valid got=%b exp=0", if1.out_valid); end
        if (if1.out_result !== 32'd0) begin bad++; $display("FAIL reset out_result got=%h exp=0", if1.out_result); end
        if (if1.out_tag !== 6'd0)     begin bad++; $display("FAIL reset out_tag got=%0d exp=0", if1.out_tag); end
        if (if1.out_div0 !== 1'b0)    begin bad++; $display("FAIL reset out_div0 got=%b exp=0", if1.out_div0); end
        if (if1.in_ready !== 1'b1)    begin bad++; $display("FAIL reset in_ready got=%b exp=1", if1.in_ready); end
        if (dbg1 !== 2'd0 || dbg2 !== 2'd0) begin
            bad++; $display("FAIL reset state got=%0d/%0d exp=0/0", dbg1, dbg2);
        end
    endtask

    task automatic test_basic();
        run_op(0, "divu_100_7", 2'b01, 32'd100, 32'd7, 6'd1);
        run_op(0, "remu_100_7", 2'b11, 32'd100, 32'd7, 6'd2);
        run_op(0, "div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 6'd3);
        run_op(0, "rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 6'd4);
        run_op(0, "div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 6'd5);
        run_op(0, "rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 6'd6);
        run_op(0, "divu_big",   2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 6'd7);
    endtask

    task automatic test_special();
        run_op(0, "div_5_0",    2'b00, 32'd5, 32'd0, 6'd10);
        run_op(0, "remu_5_0",   2'b11, 32'd5, 32'd0, 6'd11);
        run_op(0, "div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12);
        run_op(0, "rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13);
        run_op(0, "divu_no_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 6'd14);
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] hold_res;
        logic [5:0]  hold_tag;
        if1.out_ready = 1'b0;
        push_exp(0, 2'b01, 32'd1000, 32'd9, 6'd21);
        hold_res = exp_res_q[0];
        hold_tag = 6'd21;
        @(negedge clk);
        drive(0, 2'b01, 32'd1000, 32'd9, 6'd21);
        @(posedge clk);
        @(negedge clk);
        clear_valid(0);
        wait_result(0, lat);
        check_result(0, "hold_first", lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total += 3;
            if (if1.out_valid !== 1'b1 || if1.out_result !== hold_res) begin
                bad++; $display("FAIL hold result got=%h exp=%h", if1.out_result, hold_res);
            end
            if (if1.out_tag !== hold_tag) begin
                bad++; $display("FAIL hold tag got=%0d exp=%0d", if1.out_tag, hold_tag);
            end
            if (if1.in_ready !== 1'b0) begin
                bad++; $display("FAIL hold in_ready got=%b exp=0", if1.in_ready);
            end
        end
        if1.out_ready = 1'b1;
        push_exp(0, 2'b11, 32'd1000, 32'd9, 6'd22);
        drive(0, 2'b11, 32'd1000, 32'd9, 6'd22);
        @(posedge clk);
        @(negedge clk);
        total += 2;
        if (if1.out_valid !== 1'b0 || dbg1 !== 2'd0) begin
            bad++; $display("FAIL b2b idle got valid=%b state=%0d exp valid=0 state=0", if1.out_valid, dbg1);
        end
        if (if1.in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b in_ready got=%b exp=1", if1.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        clear_valid(0);
        total++;
        if (dbg1 !== 2'd1) begin
            bad++; $display("FAIL b2b accept state got=%0d exp=1", dbg1);
        end
        wait_result(0, lat);
        check_result(0, "b2b_second", lat);
        @(negedge clk);
    endtask

    task automatic test_flush();
        int hits;
        @(negedge clk);
        drive(0, 2'b01, 32'd12345, 32'd3, 6'd30);
        @(posedge clk);
        @(negedge clk);
        clear_valid(0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        drive(0, 2'b01, 32'd77, 32'd5, 6'd31);
        total += 2;
        if (dbg1 !== 2'd1) begin bad++; $display("FAIL flush pre state got=%0d exp=1", dbg1); end
        if (if1.in_ready !== 1'b0) begin bad++; $display("FAIL flush in_ready got=%b exp=0", if1.in_ready); end
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        clear_valid(0);
        total++;
        if (dbg1 !== 2'd0) begin bad++; $display("FAIL flush state got=%0d exp=0", dbg1); end
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (if1.out_valid === 1'b1) hits++;
        end
        total += 2;
        if (hits != 0) begin bad++; $display("FAIL flush out_valid cycles got=%0d exp=0", hits); end
        if (dbg1 !== 2'd0) begin bad++; $display("FAIL flush accepted state got=%0d exp=0", dbg1); end
    endtask

    task automatic test_rst_mid_busy();
        @(negedge clk);
        drive(0, 2'b00, 32'hFFFF_0000, 32'd17, 6'd40);
        @(posedge clk);
        @(negedge clk);
        clear_valid(0);
        repeat (5) @(negedge clk);
        rst   = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total += 2;
        if (dbg1 !== 2'd0 || if1.out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid state got=%0d valid=%b exp=0/0", dbg1, if1.out_valid);
        end
        if (if1.out_result !== 32'd0 || if1.out_tag !== 6'd0 || if1.out_div0 !== 1'b0) begin
            bad++; $display("FAIL rst_mid outputs got=%h/%0d/%b exp=0/0/0", if1.out_result, if1.out_tag, if1.out_div0);
        end
        rst   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        total++;
        if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid in_ready got=%b exp=1", if1.in_ready); end
    endtask

    task automatic test_bpc2_sweep();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = 32'd0 - 32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(1, "sweep", op, a, b, 6'($urandom_range(0, 63)));
        end
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        if1.in_valid  = 1'b0; if1.in_op = 2'b00; if1.in_a = '0; if1.in_b = '0; if1.in_tag = '0;
        if1.out_ready = 1'b1;
        if2.in_valid  = 1'b0; if2.in_op = 2'b00; if2.in_a = '0; if2.in_b = '0; if2.in_tag = '0;
        if2.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_special();
        test_back_to_back();
        test_flush();
        test_rst_mid_busy();
        test_bpc2_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_seq_rv.md
DIV_SEQ_RV -- requirements
Module: div_seq_rv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >= 4).
REQ-002 SHALL have parameter BITS_PER_CYC, default 1, quotient bits retired per iteration cycle (1 or 2; WIDTH divisible by it).
REQ-003 SHALL have parameter TAG_W, default 6, width of the opaque tag carried with each operation.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous kill of any in-flight operation.
REQ-007 SHALL have port in_valid, input, 1, request present.
REQ-008 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-009 SHALL have port in_op, input, 2, 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-010 SHALL have ports in_a, in_b, input, WIDTH each, dividend and divisor.
REQ-011 SHALL have port in_tag, input, TAG_W, tag returned with the result.
REQ-012 SHALL have port out_valid, output, 1, result present.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-014 SHALL have ports out_result (WIDTH) and out_tag (TAG_W), outputs, selected result and its tag.
REQ-015 SHALL have port out_div0, output, 1, result came from a zero divisor.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; accept = in_valid && in_ready.
REQ-017 in_ready SHALL be 1 only in IDLE and when flush is 0.
REQ-018 On accept SHALL latch op, tag, operand signs and magnitudes (abs for DIV/REM, raw for DIVU/REMU) and load iteration counter N = WIDTH/BITS_PER_CYC.
REQ-019 Normal accept: IDLE->BUSY; each BUSY cycle SHALL perform BITS_PER_CYC restoring shift-subtract steps and decrement the counter; after the cycle where the counter reaches 0, BUSY->DONE.
REQ-020 Normal latency: out_valid SHALL rise exactly N+1 cycles after the accept edge (33 for WIDTH=32, BITS_PER_CYC=1).
REQ-021 Sign fix-up SHALL occur on BUSY->DONE: quotient negated if dividend and divisor signs differ (signed ops), remainder takes dividend sign.
REQ-022 Divisor zero: accept SHALL go IDLE->DONE directly (out_valid 1 cycle after accept), quotient all ones, remainder = in_a, out_div0 = 1.
REQ-023 Signed overflow (DIV/REM, in_a = most-negative, in_b = all ones): IDLE->DONE directly, quotient = in_a, remainder = 0, out_div0 = 0.
REQ-024 out_result SHALL be quotient for DIV/DIVU, remainder for REM/REMU; out_tag = latched tag.
REQ-025 DONE SHALL hold out_valid, out_result, out_tag, out_div0 stable until out_valid && out_ready, then go to IDLE next cycle.
REQ-026 out_valid SHALL be 1 only in DONE; out_result/out_tag/out_div0 SHALL be 0 outside DONE.
REQ-027 flush SHALL force IDLE on the next edge from any state, discarding the operation and any undelivered result; flush has priority over accept and over result handshake.
REQ-028 No combinational path SHALL exist from in_* to out_*.

Reset
REQ-029 rst SHALL force IDLE on the next edge, overriding flush and all handshakes, including mid-BUSY.
REQ-030 After reset: out_valid = 0, out_result = 0, out_tag = 0, out_div0 = 0, counter = 0, in_ready = 1 once rst deasserts.

Verification
REQ-031 DIVU a=100 b=7 accepted, out_ready=1 -> out_result=14, out_valid exactly 33 cycles after accept (WIDTH=32, BPC=1); REMU same -> 2.
REQ-032 DIV a=-7 b=2 -> 0xFFFFFFFD; REM a=-7 b=2 -> 0xFFFFFFFF; DIV a=7 b=-2 -> 0xFFFFFFFD.
REQ-033 DIV a=5 b=0 -> 0xFFFFFFFF, out_div0=1, 1-cycle latency; REMU a=5 b=0 -> 5; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000, REM same -> 0.
REQ-034 Result held with out_ready=0 for 10 cycles -> out_result/out_tag stable, in_ready=0; out_ready=1 -> IDLE next cycle, back-to-back request accepted.
REQ-035 flush at BUSY cycle 10 with in_valid=1 -> no accept that cycle, IDLE next cycle, no out_valid; rst mid-BUSY -> all outputs 0, in_ready=1 after deassert.
REQ-036 BITS_PER_CYC=2 random signed/unsigned sweep vs reference model -> all results match, latency 17.
